// File: rtl/monolith_round_unit.sv
// One Monolith-31 round over a 16-word GF(2^31-1) state, one layer per cycle.
// CAPTURE latch input | BARS limb S-boxes | BRICKS square-add | ADD_CONC MDS + constants | DONE hold
module monolith_round_unit #(
    parameter int WORD_WIDTH   = 31,
    parameter int STATE_SIZE   = 16,
    parameter int BAR_OP_COUNT = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             pre_round,
    input  logic [WORD_WIDTH*STATE_SIZE-1:0] state_in,
    input  logic [WORD_WIDTH*STATE_SIZE-1:0] constants,
    output logic [WORD_WIDTH*STATE_SIZE-1:0] state_out,
    output logic                             valid
);

    localparam int W  = WORD_WIDTH;
    localparam int N  = STATE_SIZE;
    localparam int SW = W * N;
    localparam logic [W-1:0] P = {W{1'b1}};
    localparam logic [15:0] MDS [16] = '{
        16'd61402, 16'd1108,  16'd28750, 16'd33823, 16'd7454,  16'd43244, 16'd53865, 16'd12034,
        16'd56951, 16'd27521, 16'd41351, 16'd40901, 16'd12021, 16'd59689, 16'd26798, 16'd17845
    };

    typedef enum logic [2:0] {
        S_CAPTURE,
        S_BARS,
        S_BRICKS,
        S_ADD_CONC,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [SW-1:0]   r_work;
    logic            r_pre;
    logic [SW-1:0]   r_state_out = '0;
    logic [SW-1:0]   w_bars;
    logic [SW-1:0]   w_bricks;
    logic [SW-1:0]   w_conc;

    // Two folds bring any 64-bit sum below p+8, so one subtract is enough.
    function automatic logic [W-1:0] mod_p(input logic [63:0] x);
        logic [33:0] s1;
        logic [31:0] s2;
        s1 = 34'(x[W-1:0]) + 34'(x[63:W]);
        s2 = 32'(s1[W-1:0]) + 32'(s1[33:W]);
        if (s2 >= 32'(P))
            s2 = s2 - 32'(P);
        return s2[W-1:0];
    endfunction

    function automatic logic [7:0] sbox8(input logic [7:0] y);
        logic [7:0] t;
        t = y ^ ({~y[6:0], ~y[7]} & {y[5:0], y[7:6]} & {y[4:0], y[7:5]});
        return {t[6:0], t[7]};
    endfunction

    function automatic logic [6:0] sbox7(input logic [6:0] y);
        logic [6:0] t;
        t = y ^ ({~y[5:0], ~y[6]} & {y[4:0], y[6:5]} & {y[3:0], y[6:4]});
        return {t[5:0], t[6]};
    endfunction

    function automatic logic [W-1:0] bars_word(input logic [W-1:0] x);
        logic [W-1:0] b;
        b = {sbox7(x[30:24]), sbox8(x[23:16]), sbox8(x[15:8]), sbox8(x[7:0])};
        return (b == P) ? '0 : b;
    endfunction

    function automatic logic [W-1:0] concrete_word(input logic [SW-1:0] x, input logic [SW-1:0] c,
                                                   input logic add_c, input int i);
        logic [63:0] acc;
        logic [3:0]  k;
        acc = '0;
        for (int j = 0; j < N; j++) begin
            k   = 4'(j - i);
            acc = acc + 64'(x[j*W +: W]) * 64'(MDS[k]);
        end
        if (add_c)
            acc = acc + 64'(c[i*W +: W]);
        return mod_p(acc);
    endfunction

    always_comb begin
        w_bars   = r_work;
        w_bricks = r_work;
        w_conc   = '0;
        for (int i = 0; i < BAR_OP_COUNT; i++)
            w_bars[i*W +: W] = bars_word(r_work[i*W +: W]);
        for (int i = 1; i < N; i++)
            w_bricks[i*W +: W] = mod_p(64'(r_work[i*W +: W])
                                 + 64'(r_work[(i-1)*W +: W]) * 64'(r_work[(i-1)*W +: W]));
        for (int i = 0; i < N; i++)
            w_conc[i*W +: W] = concrete_word(r_work, constants, !r_pre, i);
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_CAPTURE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CAPTURE:  w_next = pre_round ? S_ADD_CONC : S_BARS;
            S_BARS:     w_next = S_BRICKS;
            S_BRICKS:   w_next = S_ADD_CONC;
            S_ADD_CONC: w_next = S_DONE;
            S_DONE:     w_next = S_DONE;
            default:    w_next = S_CAPTURE;
        endcase
    end

    // state_out deliberately survives reset so the parent can feed it back.
    always_ff @(posedge clk) begin
        if (!reset) begin
            case (r_state)
                S_CAPTURE: begin
                    r_work <= state_in;
                    r_pre  <= pre_round;
                end
                S_BARS:     r_work      <= w_bars;
                S_BRICKS:   r_work      <= w_bricks;
                S_ADD_CONC: r_state_out <= w_conc;
                default:    ;
            endcase
        end
    end

    assign state_out = r_state_out;
    assign valid     = (r_state == S_DONE);

endmodule

// File: tb/tb_monolith_round_unit.sv
// Bench for monolith_round_unit: vector table plus abort and chaining sequences.
module tb_monolith_round_unit;

    localparam int W  = 31;
    localparam int N  = 16;
    localparam int SW = W * N;
    localparam longint unsigned P = 64'h7FFF_FFFF;

    typedef logic [W-1:0] word_t;
    typedef word_t vec_t [16];
    typedef struct {
        bit   pre;
        vec_t st;
        vec_t cn;
        vec_t exp;
        int   lat;
    } vec_rec_t;

    longint unsigned mds_row [16] = '{
        61402, 1108, 28750, 33823, 7454, 43244, 53865, 12034,
        56951, 27521, 41351, 40901, 12021, 59689, 26798, 17845
    };

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pre_round = 1'b0;
    logic [SW-1:0] state_in = '0;
    logic [SW-1:0] constants = '0;
    logic [SW-1:0] state_out;
    logic          valid;

    int n_checks = 0;
    int n_fail   = 0;

    monolith_round_unit #(.WORD_WIDTH(31), .STATE_SIZE(16), .BAR_OP_COUNT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .pre_round (pre_round),
        .state_in  (state_in),
        .constants (constants),
        .state_out (state_out),
        .valid     (valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    function automatic longint unsigned rotl(input longint unsigned v, input int r, input int w);
        longint unsigned mask;
        mask = (64'd1 << w) - 1;
        return ((v << r) | (v >> (w - r))) & mask;
    endfunction

    function automatic longint unsigned sbox_model(input longint unsigned y, input int w);
        longint unsigned mask, t;
        mask = (64'd1 << w) - 1;
        t = y ^ (rotl((~y) & mask, 1, w) & rotl(y, 2, w) & rotl(y, 3, w));
        return rotl(t, 1, w);
    endfunction

    task automatic model_round(input vec_t s, input vec_t c, input bit pre, output vec_t o);
        longint unsigned x [16];
        longint unsigned y [16];
        longint unsigned acc, v, limb;
        int width;
        for (int i = 0; i < N; i++) x[i] = s[i];
        if (!pre) begin
            for (int i = 0; i < 8; i++) begin
                v = 0;
                for (int l = 0; l < 4; l++) begin
                    width = (l == 3) ? 7 : 8;
                    limb  = (x[i] >> (8 * l)) & ((64'd1 << width) - 1);
                    v     = v | (sbox_model(limb, width) << (8 * l));
                end
                x[i] = (v == P) ? 0 : v;
            end
            y[0] = x[0];
            for (int i = 1; i < N; i++) y[i] = (x[i] + x[i-1] * x[i-1]) % P;
            for (int i = 0; i < N; i++) x[i] = y[i];
        end
        for (int i = 0; i < N; i++) begin
            acc = 0;
            for (int j = 0; j < N; j++) acc = (acc + mds_row[(j - i + 16) % 16] * x[j]) % P;
            if (!pre) acc = (acc + c[i]) % P;
            o[i] = word_t'(acc);
        end
    endtask

    function automatic logic [SW-1:0] pack(input vec_t v);
        logic [SW-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = v[i];
        return r;
    endfunction

    function automatic word_t rand_word();
        return word_t'($urandom_range(32'h7FFF_FFFE, 0));
    endfunction

    task automatic read_out(output vec_t got);
        for (int i = 0; i < N; i++) got[i] = state_out[i*W +: W];
    endtask

    // One-cycle reset with inputs presented, then count cycles to valid.
    task automatic run_round(input bit pre, input vec_t st, input vec_t cn,
                             output vec_t got, output int lat);
        reset     = 1'b1;
        pre_round = pre;
        state_in  = pack(st);
        constants = pack(cn);
        @(posedge clk); #1;
        check("valid_after_reset", longint'(valid), 0);
        reset = 1'b0;
        lat   = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (valid) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) $display("FAIL valid_wait got=timeout expected=valid");
        read_out(got);
    endtask

    task automatic compare_vec(input string tag, input vec_t got, input vec_t exp);
        for (int i = 0; i < N; i++)
            check($sformatf("%s_w%0d", tag, i), longint'(got[i]), longint'(exp[i]));
    endtask

    vec_rec_t tbl [8];
    vec_t     got, s0, c1, c2, mid, exp2, a_st, a_cn;
    int       lat;
    bit       canon;

    initial begin
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) begin
                tbl[k].st[i]  = '0;
                tbl[k].cn[i]  = '0;
                tbl[k].exp[i] = '0;
            end
        end
        tbl[0].pre = 1'b0;
        for (int i = 0; i < N; i++) begin
            tbl[0].cn[i]  = word_t'(i + 1);
            tbl[0].exp[i] = word_t'(i + 1);
        end
        tbl[1].pre   = 1'b1;
        tbl[1].st[0] = word_t'(1);
        for (int i = 0; i < N; i++) begin
            tbl[1].cn[i]  = rand_word();
            tbl[1].exp[i] = word_t'(mds_row[(16 - i) % 16]);
        end
        tbl[2].pre   = 1'b0;
        tbl[2].st[0] = word_t'(1);
        tbl[3].pre = 1'b0;
        for (int i = 0; i < N; i++) begin
            tbl[3].st[i] = word_t'(P - 1);
            tbl[3].cn[i] = rand_word();
        end
        for (int k = 4; k < 8; k++) begin
            tbl[k].pre = (k == 5);
            for (int i = 0; i < N; i++) begin
                tbl[k].st[i] = rand_word();
                tbl[k].cn[i] = rand_word();
            end
        end
        for (int k = 2; k < 8; k++) model_round(tbl[k].st, tbl[k].cn, tbl[k].pre, tbl[k].exp);
        for (int k = 0; k < 8; k++) tbl[k].lat = tbl[k].pre ? 2 : 4;

        repeat (3) @(posedge clk);
        #1;

        for (int k = 0; k < 8; k++) begin
            run_round(tbl[k].pre, tbl[k].st, tbl[k].cn, got, lat);
            check($sformatf("t%0d_latency", k), longint'(lat), longint'(tbl[k].lat));
            compare_vec($sformatf("t%0d", k), got, tbl[k].exp);
            canon = 1'b1;
            for (int i = 0; i < N; i++) if (longint'(got[i]) >= P) canon = 1'b0;
            check($sformatf("t%0d_canonical", k), longint'(canon), 1);
            if (k == 0) begin
                // Sticky valid; inputs wiggling in DONE must not retrigger.
                for (int c = 0; c < 20; c++) begin
                    state_in  = pack(tbl[7].st);
                    pre_round = c[0];
                    constants = pack(tbl[6].cn);
                    @(posedge clk); #1;
                    check($sformatf("t0_sticky_c%0d", c), longint'(valid), 1);
                end
                read_out(got);
                compare_vec("t0_hold", got, tbl[0].exp);
            end
        end

        // Abort in BRICKS (cycle 2) and in ADD_CONC (cycle 3).
        for (int ab = 2; ab <= 3; ab++) begin
            for (int i = 0; i < N; i++) begin
                a_st[i] = rand_word();
                a_cn[i] = rand_word();
            end
            reset     = 1'b1;
            pre_round = 1'b0;
            state_in  = pack(a_st);
            constants = pack(a_cn);
            @(posedge clk); #1;
            reset = 1'b0;
            repeat (ab) begin
                @(posedge clk); #1;
            end
            reset = 1'b1;
            @(posedge clk); #1;
            check($sformatf("abort%0d_valid", ab), longint'(valid), 0);
            @(posedge clk); #1;
            check($sformatf("abort%0d_valid2", ab), longint'(valid), 0);
            read_out(got);
            compare_vec($sformatf("abort%0d_keep", ab), got, tbl[7].exp);
        end
        for (int i = 0; i < N; i++) begin
            a_st[i] = rand_word();
            a_cn[i] = rand_word();
        end
        model_round(a_st, a_cn, 1'b0, exp2);
        run_round(1'b0, a_st, a_cn, got, lat);
        check("restart_latency", longint'(lat), 4);
        compare_vec("restart", got, exp2);

        // Chained: initial Concrete pass, then a full round fed from state_out.
        for (int i = 0; i < N; i++) begin
            s0[i] = rand_word();
            c1[i] = rand_word();
            c2[i] = rand_word();
        end
        model_round(s0, c1, 1'b1, mid);
        model_round(mid, c2, 1'b0, exp2);
        run_round(1'b1, s0, c1, got, lat);
        check("chain1_latency", longint'(lat), 2);
        compare_vec("chain1", got, mid);
        run_round(1'b0, got, c2, got, lat);
        check("chain2_latency", longint'(lat), 4);
        compare_vec("chain2", got, exp2);
        model_round(exp2, c1, 1'b0, mid);
        run_round(1'b0, got, c1, got, lat);
        check("chain3_latency", longint'(lat), 4);
        compare_vec("chain3", got, mid);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
